// File: rtl/seq_addsub.sv
// Multi-cycle two's-complement adder/subtractor, CHUNK bits per clock, LSB chunk first.
// Optional build macro: SEQ_ADDSUB_SATURATE_EN clamps sum to max pos / min neg on signed overflow.
module seq_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [CHUNK:0]   chunk_full;
    logic [WIDTH-1:0] res_next;
    logic             ovf_calc;
    logic [WIDTH-1:0] sat_val;

    always_comb begin
        chunk_full = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};
        // New chunk enters from the MSB side; after N shifts the LSB chunk lands at bit 0.
        res_next   = (res_q >> CHUNK) | (WIDTH'(chunk_full[CHUNK-1:0]) << (WIDTH - CHUNK));
        ovf_calc   = (a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
        sat_val    = a_msb_q ? (WIDTH'(1) << (WIDTH - 1)) : ~(WIDTH'(1) << (WIDTH - 1));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = mode ? ~b : b;
                    carry_d = mode;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = mode ? ~b[WIDTH-1] : b[WIDTH-1];
                    res_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = chunk_full[CHUNK];
                res_d   = res_next;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    cout_d  = chunk_full[CHUNK];
                    ovf_d   = ovf_calc;
`ifdef SEQ_ADDSUB_SATURATE_EN
                    sum_d   = ovf_calc ? sat_val : res_next;
`else
                    sum_d   = res_next;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

`ifndef SEQ_ADDSUB_SATURATE_EN
    logic unused_sat;
    assign unused_sat = ^sat_val;
`endif

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
